// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// ALU operation encoding, FSM state type and small decode helpers.
package core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // True for every opcode/funct pair the core can execute (HALT excluded).
    function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                           (fn == FN_OR)  || (fn == FN_SLT);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_op_t funct_to_op(input logic [5:0] fn);
        alu_op_t op;
        case (fn)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational 32-bit ALU; arithmetic wraps, slt is a signed compare.
module core_alu
    import core_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select; zero flag feeds the beq/bne decision.
    always_comb begin
        result = a + b;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            default: result = a + b;
        endcase
        zero = (result == 32'h0);
    end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core with a single shared req/ready memory port.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_FETCH  | request instruction at pc, latch IR and pc+4 on ready
// S_DECODE | read rs/rt into A/B, trap HALT and illegal encodings
// S_EXEC   | ALU / address calc; branches and jumps retire here
// S_MEM    | data access at ALUout; sw retires, lw latches MDR
// S_WB     | register write-back, retire
// S_HALT   | stopped until reset, no memory requests
module multicycle_core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_out,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retire_count
);

    state_t            state, state_next;
    logic [31:0]       pc, ir, a_q, b_q, alu_out, mdr;
    logic              illegal_q;
    logic [CNT_W-1:0]  retire_cnt;
    logic [31:0]       regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] imm_sext;

    logic [31:0] alu_a, alu_b, alu_result;
    alu_op_t     alu_op;
    logic        alu_zero;

    logic        retire, set_illegal, reg_we, branch_taken;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign target   = ir[25:0];
    assign imm_sext = sext16(imm);

    assign wb_dst  = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data = (opcode == OP_LW) ? mdr : alu_out;

    assign pc_out       = pc;
    assign halted       = (state == S_HALT);
    assign illegal      = illegal_q;
    assign retire_count = retire_cnt;

    core_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Memory port driven straight from state so reset drops the request at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state == S_FETCH) begin
                mem_req  = 1'b1;
                mem_addr = pc[ADDR_W-1:0];
            end else if (state == S_MEM) begin
                mem_req   = 1'b1;
                mem_we    = (opcode == OP_SW);
                mem_addr  = alu_out[ADDR_W-1:0];
                mem_wdata = b_q;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next-state, ALU operand selection and retire/fault strobes.
    always_comb begin
        state_next   = state;
        alu_a        = a_q;
        alu_b        = b_q;
        alu_op       = ALU_ADD;
        retire       = 1'b0;
        set_illegal  = 1'b0;
        reg_we       = 1'b0;
        branch_taken = 1'b0;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else if (!op_legal(opcode, funct)) begin
                    state_next  = S_HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_op     = funct_to_op(funct);
                        state_next = S_WB;
                    end
                    OP_ADDI: begin
                        alu_b      = imm_sext;
                        state_next = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_b = imm_sext;
                        if (alu_result[1:0] != 2'b00) begin
                            state_next  = S_HALT;
                            set_illegal = 1'b1;
                        end else begin
                            state_next = S_MEM;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op       = ALU_SUB;
                        branch_taken = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
                        retire       = 1'b1;
                        state_next   = S_FETCH;
                    end
                    OP_J: begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        state_next  = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
    end

    // Datapath registers: pc, IR, A/B, ALUout, MDR, fault flag and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            illegal_q  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_q <= regs[rs];
                    b_q <= regs[rt];
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    if (branch_taken) pc <= pc + {imm_sext[29:0], 2'b00};
                    if (opcode == OP_J) pc <= {pc[31:28], target, 2'b00};
                end
                S_MEM: if (mem_ready && opcode == OP_LW) mdr <= mem_rdata;
                default: ;
            endcase
            if (set_illegal) illegal_q  <= 1'b1;
            if (retire)      retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Register file; register 0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we && wb_dst != 5'd0) begin
            regs[wb_dst] <= wb_data;
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs on a wait-state memory model.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc_out;
    logic        halted, illegal;
    logic [31:0] retire_count;

    int vectors = 0;
    int miscompares = 0;

    // memory model state
    logic [31:0] mem [128];
    int          wait_states = 0;
    logic        mem_hold = 1'b0;
    int          wcnt = 0;
    int          held = 0;
    logic [31:0] t_addr, t_wdata;
    logic        t_we;
    logic [31:0] acc_log [$];
    int          st_count = 0;
    logic [31:0] st_addr = 32'h0, st_data = 32'h0;
    int          st_held = 0;
    int          cyc;

    multicycle_core dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .pc_out       (pc_out),
        .halted       (halted),
        .illegal      (illegal),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: ready after wait_states cycles, checks request stability.
    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
        if (rst) begin
            wcnt = 0;
        end else if (mem_req && !mem_hold) begin
            if (wcnt == 0) begin
                t_addr  = mem_addr;
                t_we    = mem_we;
                t_wdata = mem_wdata;
                held    = 0;
                if (!mem_we) acc_log.push_back(mem_addr);
            end else begin
                vectors++;
                assert ({mem_addr, mem_we, mem_wdata} === {t_addr, t_we, t_wdata}) else begin
                    miscompares++;
                    $error("FAIL req_stable: observed %h/%b/%h expected %h/%b/%h",
                           mem_addr, mem_we, mem_wdata, t_addr, t_we, t_wdata);
                end
            end
            held++;
            if (wcnt == wait_states) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[8:2]];
                if (mem_we) begin
                    mem[mem_addr[8:2]] = mem_wdata;
                    st_count++;
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                    st_held = held;
                end
            end
            wcnt++;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'hFC00_0000;
    endtask

    // Reset released 1 ns after a rising edge; the next edge is the first fetch edge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        acc_log.delete();
        st_count = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!halted && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        check("halt_reached", {31'b0, halted}, 32'h1);
    endtask

    initial begin
        // ---- reset state
        #2;
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_retire", retire_count, 32'h0);

        // ---- ALU program, zero wait states
        clear_mem();
        mem[0] = 32'h2001_0005;   // addi $1,$0,5
        mem[1] = 32'h2002_FFFD;   // addi $2,$0,-3
        mem[2] = 32'h0022_1820;   // add  $3,$1,$2
        mem[3] = 32'h0041_2022;   // sub  $4,$2,$1
        mem[4] = 32'h0041_282A;   // slt  $5,$2,$1
        wait_states = 0;
        do_reset();
        wait_halt(cyc);
        // 5 x 4-cycle instructions + fetch/decode of HALT: halted after 22nd edge,
        // i.e. 21 cycles after the first fetch edge.
        check("alu_cycles", cyc, 32'd22);
        check("alu_r3", dut.regs[3], 32'h0000_0002);
        check("alu_r4", dut.regs[4], 32'hFFFF_FFF8);
        check("alu_r5", dut.regs[5], 32'h0000_0001);
        check("alu_illegal", {31'b0, illegal}, 32'h0);
        check("alu_retire", retire_count, 32'd5);

        // ---- reset in the middle of a stalled fetch
        mem_hold = 1'b1;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check("stall_req", {31'b0, mem_req}, 32'h1);
        check("stall_retire", retire_count, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", {31'b0, mem_req}, 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("postrst_req", {31'b0, mem_req}, 32'h1);
        check("postrst_pc", mem_addr, 32'h0);
        mem_hold = 1'b0;

        // ---- store/load with 3 wait states, program placed at 0x100
        clear_mem();
        mem[0]  = 32'h0800_0040;  // j 0x40 -> 0x100
        mem[2]  = 32'h1234_5678;
        mem[64] = 32'h2001_0005;  // addi $1,$0,5
        mem[65] = 32'hAC01_0008;  // sw $1,8($0)
        mem[66] = 32'h8C06_0008;  // lw $6,8($0)
        wait_states = 3;
        do_reset();
        wait_halt(cyc);
        check("st_count", st_count, 32'd1);
        check("st_addr", st_addr, 32'h8);
        check("st_data", st_data, 32'h5);
        check("st_held", st_held, 32'd4);
        check("ld_r6", dut.regs[6], 32'h5);
        check("j_target", acc_log[1], 32'h100);
        check("ld_addr", acc_log[4], 32'h8);
        check("mem_retire", retire_count, 32'd4);

        // ---- branches and jump
        clear_mem();
        mem[0] = 32'h2001_0005;   // addi $1,$0,5
        mem[1] = 32'h2002_0001;
        mem[2] = 32'h2002_0001;
        mem[3] = 32'h2002_0001;
        mem[4] = 32'h1021_0002;   // 0x10: beq $1,$1,+2
        mem[7] = 32'h1421_0002;   // 0x1C: bne $1,$1,+2
        mem[8] = 32'h0800_0040;   // 0x20: j 0x40
        wait_states = 0;
        do_reset();
        wait_halt(cyc);
        check("br_nfetch", acc_log.size(), 32'd8);
        check("beq_taken", acc_log[5], 32'h1C);
        check("bne_fall", acc_log[6], 32'h20);
        check("j_fetch", acc_log[7], 32'h100);
        check("br_retire", retire_count, 32'd7);

        // ---- illegal opcode 0x3E
        clear_mem();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'hF800_0000;
        do_reset();
        wait_halt(cyc);
        check("ilop_illegal", {31'b0, illegal}, 32'h1);
        check("ilop_retire", retire_count, 32'd1);
        check("ilop_stores", st_count, 32'd0);

        // ---- misaligned lw
        clear_mem();
        mem[0] = 32'h2001_0002;   // addi $1,$0,2
        mem[1] = 32'h8C26_0000;   // lw $6,0($1)
        do_reset();
        wait_halt(cyc);
        check("mis_illegal", {31'b0, illegal}, 32'h1);
        check("mis_retire", retire_count, 32'd1);
        check("mis_r6", dut.regs[6], 32'h0);
        check("mis_access", acc_log.size(), 32'd2);

        // ---- unsupported funct
        clear_mem();
        mem[0] = 32'h0022_1821;
        do_reset();
        wait_halt(cyc);
        check("fn_illegal", {31'b0, illegal}, 32'h1);
        check("fn_retire", retire_count, 32'd0);

        // ---- register zero
        clear_mem();
        mem[0] = 32'h2000_0007;   // addi $0,$0,7
        mem[1] = 32'h0000_3820;   // add  $7,$0,$0
        do_reset();
        wait_halt(cyc);
        check("r0_r7", dut.regs[7], 32'h0);
        check("r0_retire", retire_count, 32'd2);
        check("r0_illegal", {31'b0, illegal}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
